// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states
// and the datapath mux select codes.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_HLT = 3'd5
  } state_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_CMP   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  typedef struct packed {
    logic r;
    logic i;
    logic lw;
    logic sw;
    logic br;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic halt;
  } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational opcode classifier: one-hot class plus an illegal flag.
// The halt opcode is its own class and is never reported as illegal.
module opcode_class
  import ctrl_pkg::*;
#(
  parameter logic [6:0] HALT_OPCODE = OP_SYSTEM
) (
  input  logic [6:0] opcode,
  output op_class_t  cls,
  output logic       illegal
);

  always_comb begin
    cls       = '0;
    cls.r     = (opcode == OP_R);
    cls.i     = (opcode == OP_I);
    cls.lw    = (opcode == OP_LW);
    cls.sw    = (opcode == OP_SW);
    cls.br    = (opcode == OP_BR);
    cls.jal   = (opcode == OP_JAL);
    cls.jalr  = (opcode == OP_JALR);
    cls.lui   = (opcode == OP_LUI);
    cls.auipc = (opcode == OP_AUIPC);
    cls.halt  = (opcode == HALT_OPCODE);
    illegal   = ~(|cls);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main IF/ID/EX/MEM/WB sequencer for the multicycle RV32I core. Strobes are
// decoded combinationally from the registered state and held low during reset.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int         CNT_W       = 32,
  parameter logic [6:0] HALT_OPCODE = OP_SYSTEM
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNCT3,
  input  logic             BR_COND,
  input  logic             I_MEM_ACK,
  input  logic             D_MEM_ACK,
  output logic             I_MEM_REQ,
  output logic             D_MEM_REQ,
  output logic             D_MEM_WEN,
  output logic             IR_WE,
  output logic             PC_WE,
  output logic [1:0]       PC_SEL,
  output logic             RF_WE,
  output logic [1:0]       WB_SEL,
  output logic             ALU_A_SEL,
  output logic             ALU_B_SEL,
  output logic [1:0]       ALU_OP,
  output logic [2:0]       STATE,
  output logic             HALT,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] NUM_INST
);

  state_t     state, state_nx;
  op_class_t  cls;
  logic       illegal_op;
  logic       retire;
  logic       illegal_q;
  logic [CNT_W-1:0] num_q;

  // FUNCT3 is consumed by the ALU itself when ALU_OP selects compare/funct.
  logic unused_funct3;
  assign unused_funct3 = ^FUNCT3;

  opcode_class #(.HALT_OPCODE(HALT_OPCODE)) u_class (
    .opcode  (OPCODE),
    .cls     (cls),
    .illegal (illegal_op)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IF;
      num_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (retire) num_q <= num_q + CNT_W'(1);
      if (state == S_ID && illegal_op) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IF:  if (I_MEM_ACK) state_nx = S_ID;
      S_ID:  state_nx = (cls.halt || illegal_op) ? S_HLT : S_EX;
      S_EX:  state_nx = cls.br ? S_IF : (cls.lw || cls.sw) ? S_MEM : S_WB;
      S_MEM: if (D_MEM_ACK) state_nx = cls.sw ? S_IF : S_WB;
      S_WB:  state_nx = S_IF;
      default: state_nx = S_HLT;
    endcase
  end

  always_comb begin
    I_MEM_REQ = 1'b0;
    D_MEM_REQ = 1'b0;
    D_MEM_WEN = 1'b0;
    IR_WE     = 1'b0;
    PC_WE     = 1'b0;
    PC_SEL    = PC_PLUS4;
    RF_WE     = 1'b0;
    WB_SEL    = WB_ALU;
    ALU_A_SEL = 1'b0;
    ALU_B_SEL = 1'b0;
    ALU_OP    = ALU_ADD;
    HALT      = 1'b0;
    retire    = 1'b0;
    if (!RST) begin
      case (state)
        S_IF: begin
          I_MEM_REQ = 1'b1;
          IR_WE     = I_MEM_ACK;
        end
        S_EX: begin
          ALU_A_SEL = cls.auipc | cls.jal;
          ALU_B_SEL = ~(cls.r | cls.br);
          ALU_OP    = cls.br ? ALU_CMP : (cls.r | cls.i) ? ALU_FUNCT : ALU_ADD;
          if (cls.br) begin
            PC_WE  = 1'b1;
            PC_SEL = BR_COND ? PC_BRANCH : PC_PLUS4;
            retire = 1'b1;
          end
        end
        S_MEM: begin
          D_MEM_REQ = 1'b1;
          D_MEM_WEN = cls.sw;
          if (D_MEM_ACK && cls.sw) begin
            PC_WE  = 1'b1;
            retire = 1'b1;
          end
        end
        S_WB: begin
          RF_WE  = 1'b1;
          PC_WE  = 1'b1;
          retire = 1'b1;
          WB_SEL = cls.lw ? WB_MEM : (cls.jal | cls.jalr) ? WB_PC4 : WB_ALU;
          PC_SEL = cls.jal ? PC_BRANCH : cls.jalr ? PC_JALR : PC_PLUS4;
        end
        S_HLT: HALT = 1'b1;
        default: ;
      endcase
    end
  end

  assign STATE    = state;
  assign ILLEGAL  = illegal_q;
  assign NUM_INST = num_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle strobe vectors for each
// instruction class, memory stalls, halt/illegal and mid-MEM reset.
module tb_multicycle_ctrl;

  logic        CLK, RST;
  logic [6:0]  OPCODE;
  logic [2:0]  FUNCT3;
  logic        BR_COND, I_MEM_ACK, D_MEM_ACK;
  logic        I_MEM_REQ, D_MEM_REQ, D_MEM_WEN, IR_WE, PC_WE, RF_WE;
  logic [1:0]  PC_SEL, WB_SEL, ALU_OP;
  logic        ALU_A_SEL, ALU_B_SEL, HALT, ILLEGAL;
  logic [2:0]  STATE;
  logic [31:0] NUM_INST;

  logic        i2, d2, w2, ir2, pw2, rf2, a2, b2, h2, il2;
  logic [1:0]  ps2, ws2, op2;
  logic [2:0]  st2;
  logic [1:0]  num2;

  int n_chk = 0;
  int n_fail = 0;

  multicycle_ctrl dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .BR_COND(BR_COND),
    .I_MEM_ACK(I_MEM_ACK), .D_MEM_ACK(D_MEM_ACK), .I_MEM_REQ(I_MEM_REQ),
    .D_MEM_REQ(D_MEM_REQ), .D_MEM_WEN(D_MEM_WEN), .IR_WE(IR_WE), .PC_WE(PC_WE),
    .PC_SEL(PC_SEL), .RF_WE(RF_WE), .WB_SEL(WB_SEL), .ALU_A_SEL(ALU_A_SEL),
    .ALU_B_SEL(ALU_B_SEL), .ALU_OP(ALU_OP), .STATE(STATE), .HALT(HALT),
    .ILLEGAL(ILLEGAL), .NUM_INST(NUM_INST)
  );

  // Narrow counter copy to observe wrap-around.
  multicycle_ctrl #(.CNT_W(2)) dut_w (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .BR_COND(BR_COND),
    .I_MEM_ACK(I_MEM_ACK), .D_MEM_ACK(D_MEM_ACK), .I_MEM_REQ(i2),
    .D_MEM_REQ(d2), .D_MEM_WEN(w2), .IR_WE(ir2), .PC_WE(pw2),
    .PC_SEL(ps2), .RF_WE(rf2), .WB_SEL(ws2), .ALU_A_SEL(a2),
    .ALU_B_SEL(b2), .ALU_OP(op2), .STATE(st2), .HALT(h2),
    .ILLEGAL(il2), .NUM_INST(num2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [18:0] obs;
  assign obs = {STATE, I_MEM_REQ, IR_WE, PC_WE, PC_SEL, RF_WE, WB_SEL,
                D_MEM_REQ, D_MEM_WEN, ALU_A_SEL, ALU_B_SEL, ALU_OP, HALT, ILLEGAL};

  // Packs hand-written expected strobe values into the obs layout.
  function automatic logic [18:0] e(int st, int imr, int irwe, int pcwe, int pcsel,
                                    int rfwe, int wbsel, int dreq, int dwen,
                                    int asel, int bsel, int op, int h, int il);
    return {3'(st), 1'(imr), 1'(irwe), 1'(pcwe), 2'(pcsel), 1'(rfwe), 2'(wbsel),
            1'(dreq), 1'(dwen), 1'(asel), 1'(bsel), 2'(op), 1'(h), 1'(il)};
  endfunction

  logic [18:0] E_IF, E_ID;

  task automatic test_reset_add();
    logic [18:0] x [4];
    RST = 1'b1; I_MEM_ACK = 1'b1; D_MEM_ACK = 1'b0; OPCODE = 7'b0110011;
    BR_COND = 1'b0; FUNCT3 = 3'd0;
    repeat (2) @(posedge CLK);
    #1;
    n_chk++; if (obs !== 19'd0) begin n_fail++; $display("FAIL reset_outputs got %b want %b", obs, 19'd0); end
    n_chk++; if (NUM_INST !== 32'd0) begin n_fail++; $display("FAIL reset_num got %0d want 0", NUM_INST); end
    RST = 1'b0;
    x = '{E_IF, E_ID, e(2,0,0,0,0,0,0,0,0,0,0,2,0,0), e(4,0,0,1,0,1,0,0,0,0,0,0,0,0)};
    for (int c = 0; c < 4; c++) begin
      #4;
      n_chk++; if (obs !== x[c]) begin n_fail++; $display("FAIL add_cyc%0d got %b want %b", c, obs, x[c]); end
      if (c == 3) begin
        n_chk++; if (NUM_INST !== 32'd0) begin n_fail++; $display("FAIL add_num_in_wb got %0d want 0", NUM_INST); end
      end
      @(posedge CLK); #1;
    end
    n_chk++; if (STATE !== 3'd0 || NUM_INST !== 32'd1) begin
      n_fail++; $display("FAIL add_retire got state %0d num %0d want state 0 num 1", STATE, NUM_INST); end
  endtask

  task automatic test_lw_stall();
    logic [18:0] x [8];
    logic        ack [8];
    OPCODE = 7'b0000011;
    ack = '{0, 0, 0, 0, 0, 0, 1, 0};
    x = '{E_IF, E_ID, e(2,0,0,0,0,0,0,0,0,0,1,0,0,0),
          e(3,0,0,0,0,0,0,1,0,0,0,0,0,0), e(3,0,0,0,0,0,0,1,0,0,0,0,0,0),
          e(3,0,0,0,0,0,0,1,0,0,0,0,0,0), e(3,0,0,0,0,0,0,1,0,0,0,0,0,0),
          e(4,0,0,1,0,1,1,0,0,0,0,0,0,0)};
    for (int c = 0; c < 8; c++) begin
      D_MEM_ACK = ack[c];
      #4;
      n_chk++; if (obs !== x[c]) begin n_fail++; $display("FAIL lw_cyc%0d got %b want %b", c, obs, x[c]); end
      @(posedge CLK); #1;
    end
    D_MEM_ACK = 1'b0;
    n_chk++; if (STATE !== 3'd0 || NUM_INST !== 32'd2) begin
      n_fail++; $display("FAIL lw_retire got state %0d num %0d want state 0 num 2", STATE, NUM_INST); end
  endtask

  task automatic test_branch();
    logic [18:0] x [6];
    logic        bc [6];
    OPCODE = 7'b1100011;
    bc = '{1, 1, 1, 0, 0, 0};
    x = '{E_IF, E_ID, e(2,0,0,1,1,0,0,0,0,0,0,1,0,0),
          E_IF, E_ID, e(2,0,0,1,0,0,0,0,0,0,0,1,0,0)};
    for (int c = 0; c < 6; c++) begin
      BR_COND = bc[c];
      #4;
      n_chk++; if (obs !== x[c]) begin n_fail++; $display("FAIL br_cyc%0d got %b want %b", c, obs, x[c]); end
      @(posedge CLK); #1;
    end
    n_chk++; if (STATE !== 3'd0 || NUM_INST !== 32'd4) begin
      n_fail++; $display("FAIL br_retire got state %0d num %0d want state 0 num 4", STATE, NUM_INST); end
    n_chk++; if (num2 !== 2'd0) begin n_fail++; $display("FAIL count_wrap got %0d want 0", num2); end
  endtask

  task automatic test_jump();
    logic [18:0] x [8];
    logic [6:0]  oc [8];
    oc = '{7'b1100111, 7'b1100111, 7'b1100111, 7'b1100111,
           7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
    x = '{E_IF, E_ID, e(2,0,0,0,0,0,0,0,0,0,1,0,0,0), e(4,0,0,1,2,1,2,0,0,0,0,0,0,0),
          E_IF, E_ID, e(2,0,0,0,0,0,0,0,0,1,1,0,0,0), e(4,0,0,1,1,1,2,0,0,0,0,0,0,0)};
    for (int c = 0; c < 8; c++) begin
      OPCODE = oc[c];
      #4;
      n_chk++; if (obs !== x[c]) begin n_fail++; $display("FAIL jump_cyc%0d got %b want %b", c, obs, x[c]); end
      @(posedge CLK); #1;
    end
    n_chk++; if (NUM_INST !== 32'd6 || num2 !== 2'd2) begin
      n_fail++; $display("FAIL jump_retire got num %0d narrow %0d want 6 and 2", NUM_INST, num2); end
  endtask

  task automatic test_sw_reset();
    logic [18:0] x [9];
    logic        ack [9];
    OPCODE = 7'b0100011;
    ack = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    x = '{E_IF, E_ID, e(2,0,0,0,0,0,0,0,0,0,1,0,0,0), e(3,0,0,1,0,0,0,1,1,0,0,0,0,0),
          E_IF, E_ID, e(2,0,0,0,0,0,0,0,0,0,1,0,0,0), e(3,0,0,0,0,0,0,1,1,0,0,0,0,0),
          e(3,0,0,0,0,0,0,1,1,0,0,0,0,0)};
    for (int c = 0; c < 9; c++) begin
      D_MEM_ACK = ack[c];
      #4;
      n_chk++; if (obs !== x[c]) begin n_fail++; $display("FAIL sw_cyc%0d got %b want %b", c, obs, x[c]); end
      if (c == 4) begin
        n_chk++; if (NUM_INST !== 32'd7) begin n_fail++; $display("FAIL sw_retire got %0d want 7", NUM_INST); end
      end
      @(posedge CLK); #1;
    end
    // Third cycle waiting in MEM: reset mid-cycle must drop the request at once.
    #2;
    RST = 1'b1;
    #1;
    n_chk++; if (obs !== 19'd0) begin n_fail++; $display("FAIL sw_reset_outputs got %b want %b", obs, 19'd0); end
    n_chk++; if (NUM_INST !== 32'd0) begin n_fail++; $display("FAIL sw_reset_num got %0d want 0", NUM_INST); end
    I_MEM_ACK = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    #4;
    n_chk++; if (obs !== e(0,1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
      n_fail++; $display("FAIL refetch got %b want %b", obs, e(0,1,0,0,0,0,0,0,0,0,0,0,0,0)); end
    @(posedge CLK); #1;
    n_chk++; if (STATE !== 3'd0) begin n_fail++; $display("FAIL if_stall got state %0d want 0", STATE); end
  endtask

  task automatic test_halt_illegal();
    logic [18:0] xh;
    OPCODE = 7'b1110011; I_MEM_ACK = 1'b1; D_MEM_ACK = 1'b1;
    #4;
    n_chk++; if (obs !== E_IF) begin n_fail++; $display("FAIL halt_if got %b want %b", obs, E_IF); end
    @(posedge CLK); #5;
    n_chk++; if (obs !== E_ID) begin n_fail++; $display("FAIL halt_id got %b want %b", obs, E_ID); end
    xh = e(5,0,0,0,0,0,0,0,0,0,0,0,1,0);
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #5;
      n_chk++; if (obs !== xh || NUM_INST !== 32'd0) begin
        n_fail++; $display("FAIL halt_hold%0d got %b num %0d want %b num 0", c, obs, NUM_INST, xh); end
    end
    RST = 1'b1;
    #1;
    n_chk++; if (HALT !== 1'b0 || STATE !== 3'd0) begin
      n_fail++; $display("FAIL halt_clear got halt %b state %0d want 0 0", HALT, STATE); end
    @(posedge CLK); #1;
    RST = 1'b0; OPCODE = 7'b1111111; D_MEM_ACK = 1'b0;
    @(posedge CLK); #5;
    n_chk++; if (obs !== E_ID || ILLEGAL !== 1'b0) begin
      n_fail++; $display("FAIL ill_id got %b want %b", obs, E_ID); end
    xh = e(5,0,0,0,0,0,0,0,0,0,0,0,1,1);
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #5;
      n_chk++; if (obs !== xh) begin n_fail++; $display("FAIL ill_hold%0d got %b want %b", c, obs, xh); end
    end
  endtask

  initial begin
    E_IF = e(0,1,1,0,0,0,0,0,0,0,0,0,0,0);
    E_ID = e(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
    test_reset_add();
    test_lw_stall();
    test_branch();
    test_jump();
    test_sw_reset();
    test_halt_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
